// File: rtl/uart_echo_fifo.sv
// UART echo path: RX characters are queued in a FIFO and replayed to the TX side in order.
// Overflowing characters are dropped and tallied by a sticky flag and a saturating counter.
module uart_echo_fifo #(
  parameter int P_DATA_WIDTH = 8,
  parameter int P_FIFO_DEPTH = 16,
  parameter int P_CNT_W      = 8
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic [P_DATA_WIDTH-1:0]         i_user_rx_data,
  input  logic                            i_user_rx_valid,
  output logic [P_DATA_WIDTH-1:0]         o_user_tx_data,
  output logic                            o_user_tx_valid,
  input  logic                            i_user_tx_ready,
  output logic [$clog2(P_FIFO_DEPTH):0]   o_fifo_count,
  output logic                            o_overflow,
  output logic [P_CNT_W-1:0]              o_drop_cnt
);

  localparam int AW = $clog2(P_FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] L_FULL = CW'(P_FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_SEND} state_t;

  state_t                  state;
  logic [P_DATA_WIDTH-1:0] mem [P_FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr;
  logic [AW-1:0]           rd_ptr;
  logic [CW-1:0]           count;

  logic do_wr, do_drop, do_rd;

  // Full is judged on the registered count, so a same-cycle fetch never frees a slot early.
  assign do_wr   = i_user_rx_valid && (count != L_FULL);
  assign do_drop = i_user_rx_valid && (count == L_FULL);
  assign do_rd   = (state == S_FETCH);

  assign o_fifo_count = count;

  always_ff @(posedge i_clk) begin
    if (do_wr) mem[wr_ptr] <= i_user_rx_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state           <= S_IDLE;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count           <= '0;
      o_user_tx_data  <= '0;
      o_user_tx_valid <= 1'b0;
      o_overflow      <= 1'b0;
      o_drop_cnt      <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);

      case ({do_wr, do_rd})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase

      if (do_drop) begin
        o_overflow <= 1'b1;
        if (o_drop_cnt != '1) o_drop_cnt <= o_drop_cnt + P_CNT_W'(1);
      end

      case (state)
        S_IDLE: begin
          if (count != '0) state <= S_FETCH;
        end
        S_FETCH: begin
          o_user_tx_data  <= mem[rd_ptr];
          o_user_tx_valid <= 1'b1;
          rd_ptr          <= rd_ptr + AW'(1);
          state           <= S_SEND;
        end
        S_SEND: begin
          if (i_user_tx_ready) begin
            o_user_tx_valid <= 1'b0;
            state           <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_echo_fifo.sv
// Scoreboard bench for uart_echo_fifo: stimulus pushes expected TX bytes, a negedge monitor pops them.
module tb_uart_echo_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic [4:0] fifo_count;
  logic       overflow;
  logic [7:0] drop_cnt;

  logic [7:0] s_rx_data;
  logic       s_rx_valid;
  logic       s_tx_ready;
  logic [7:0] s_tx_data;
  logic       s_tx_valid;
  logic [4:0] s_count;
  logic       s_ovf;
  logic [1:0] s_drop;

  uart_echo_fifo dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_user_rx_data(rx_data), .i_user_rx_valid(rx_valid),
    .o_user_tx_data(tx_data), .o_user_tx_valid(tx_valid), .i_user_tx_ready(tx_ready),
    .o_fifo_count(fifo_count), .o_overflow(overflow), .o_drop_cnt(drop_cnt)
  );

  uart_echo_fifo #(.P_CNT_W(2)) dut_sat (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_user_rx_data(s_rx_data), .i_user_rx_valid(s_rx_valid),
    .o_user_tx_data(s_tx_data), .o_user_tx_valid(s_tx_valid), .i_user_tx_ready(s_tx_ready),
    .o_fifo_count(s_count), .o_overflow(s_ovf), .o_drop_cnt(s_drop)
  );

  int         tests = 0;
  int         fails = 0;
  int         n_tx  = 0;
  logic [7:0] exp_q[$];
  logic       pv = 1'b0;
  logic [7:0] pd = '0;
  logic [7:0] e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rx(input logic [7:0] d, input bit push);
    if (push) exp_q.push_back(d);
    rx_data  = d;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic s_rx(input logic [7:0] d);
    s_rx_data  = d;
    s_rx_valid = 1'b1;
    tick();
    s_rx_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int k = 0;
    while ((exp_q.size() != 0 || tx_valid || fifo_count != 0) && k < 1000) begin
      tick();
      k++;
    end
    chk({name, "_drain_timeout"}, 32'(k < 1000), 32'd1);
  endtask

  // Monitor: a handshake seen at the negedge completes on the following posedge.
  always @(negedge clk) begin
    if (!rst_n) begin
      pv = 1'b0;
    end else begin
      if (pv && tx_valid) chk("tx_hold_data", 32'(tx_data), 32'(pd));
      if (tx_valid && tx_ready) begin
        n_tx++;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL tx_unexpected: got 0x%0h expected no transfer", tx_data);
        end else begin
          e = exp_q.pop_front();
          chk("tx_data", 32'(tx_data), 32'(e));
        end
      end
      pv = tx_valid && !tx_ready;
      pd = tx_data;
    end
  end

  initial begin
    int n0;
    rst_n = 1'b0; rx_valid = 1'b0; rx_data = '0; tx_ready = 1'b0;
    s_rx_valid = 1'b0; s_rx_data = '0; s_tx_ready = 1'b0;
    #1;
    chk("rst_valid", 32'(tx_valid), 0);
    chk("rst_data", 32'(tx_data), 0);
    chk("rst_count", 32'(fifo_count), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_drop", 32'(drop_cnt), 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Single echo with ready held high
    tx_ready = 1'b1;
    rx(8'hA5, 1'b1);
    chk("echo_cnt_n", 32'(fifo_count), 1);
    chk("echo_vld_n", 32'(tx_valid), 0);
    tick();
    chk("echo_vld_n1", 32'(tx_valid), 0);
    chk("echo_cnt_n1", 32'(fifo_count), 1);
    tick();
    chk("echo_vld_n2", 32'(tx_valid), 1);
    chk("echo_data_n2", 32'(tx_data), 32'hA5);
    chk("echo_cnt_n2", 32'(fifo_count), 0);
    tick();
    chk("echo_vld_n3", 32'(tx_valid), 0);
    drain("echo");

    // Backpressure: 20 cycles of ready=0
    tx_ready = 1'b0;
    rx(8'h3C, 1'b1);
    tick(); tick();
    for (int i = 0; i < 20; i++) begin
      chk("bp_vld", 32'(tx_valid), 1);
      chk("bp_data", 32'(tx_data), 32'h3C);
      tick();
    end
    n0 = n_tx;
    tx_ready = 1'b1;
    tick();
    chk("bp_vld_after", 32'(tx_valid), 0);
    repeat (5) tick();
    chk("bp_single_xfer", 32'(n_tx - n0), 1);

    // Burst with wrap on both pointers
    n0 = n_tx;
    tx_ready = 1'b0;
    for (int i = 0; i < 16; i++) rx(8'(i), 1'b1);
    chk("burst_cnt_full", 32'(fifo_count), 15);
    tx_ready = 1'b1;
    for (int i = 16; i < 26; i++) begin
      rx(8'(i), 1'b1);
      repeat (3) tick();
    end
    drain("burst");
    chk("burst_ovf", 32'(overflow), 0);
    chk("burst_xfers", 32'(n_tx - n0), 26);

    // Overflow: blocker parked in S_SEND, then 18 writes
    tx_ready = 1'b0;
    rx(8'hB0, 1'b1);
    tick(); tick();
    for (int i = 1; i <= 18; i++) rx(8'(8'h40 + i), i <= 16);
    chk("ovf_cnt", 32'(fifo_count), 16);
    chk("ovf_flag", 32'(overflow), 1);
    chk("ovf_drop", 32'(drop_cnt), 2);
    // Write while full on the fetch edge: still dropped
    tx_ready = 1'b1;
    tick(); tick();
    rx(8'h99, 1'b0);
    chk("full_rd_cnt", 32'(fifo_count), 15);
    chk("full_rd_drop", 32'(drop_cnt), 3);
    drain("ovf");

    // Reset mid-S_SEND with 5 queued
    tx_ready = 1'b0;
    rx(8'hC1, 1'b0);
    for (int i = 0; i < 5; i++) rx(8'(8'hD0 + i), 1'b0);
    chk("mid_pre_vld", 32'(tx_valid), 1);
    chk("mid_pre_cnt", 32'(fifo_count), 5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_vld", 32'(tx_valid), 0);
    chk("mid_rst_data", 32'(tx_data), 0);
    chk("mid_rst_cnt", 32'(fifo_count), 0);
    chk("mid_rst_ovf", 32'(overflow), 0);
    chk("mid_rst_drop", 32'(drop_cnt), 0);
    exp_q.delete();
    tick(); tick();
    rst_n = 1'b1;
    n0 = n_tx;
    tx_ready = 1'b1;
    repeat (10) tick();
    chk("post_rst_no_tx", 32'(n_tx - n0), 0);
    chk("post_rst_vld", 32'(tx_valid), 0);
    rx(8'h5A, 1'b1);
    tick();
    chk("post_rst_vld_n1", 32'(tx_valid), 0);
    tick();
    chk("post_rst_vld_n2", 32'(tx_valid), 1);
    chk("post_rst_data_n2", 32'(tx_data), 32'h5A);
    drain("post_rst");
    chk("post_rst_xfers", 32'(n_tx - n0), 1);

    // Drop counter saturation on the 2-bit instance
    s_rx(8'hE0);
    tick(); tick();
    for (int i = 0; i < 16; i++) s_rx(8'(i));
    chk("sat_cnt_full", 32'(s_count), 16);
    chk("sat_ovf_pre", 32'(s_ovf), 0);
    for (int i = 1; i <= 5; i++) begin
      s_rx(8'hFF);
      chk("sat_drop", 32'(s_drop), (i < 3) ? i : 3);
    end
    chk("sat_ovf", 32'(s_ovf), 1);
    chk("sat_cnt", 32'(s_count), 16);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/uart_echo_fifo.md
UART_ECHO_FIFO -- requirements
Module: uart_echo_fifo

Interface
REQ-001 The block SHALL have parameter P_DATA_WIDTH, default 8, meaning the UART character width in bits.
REQ-002 The block SHALL have parameter P_FIFO_DEPTH, default 16, meaning the number of FIFO entries; legal values are powers of 2 from 4 to 256.
REQ-003 The block SHALL have parameter P_CNT_W, default 8, meaning the width of the drop counter.
REQ-004 i_clk  input  1  is the single clock for the whole block, nominally the 50 MHz system clock.
REQ-005 i_rst_n  input  1  is the reset, which is asynchronous and active-low.
REQ-006 i_user_rx_data  input  P_DATA_WIDTH  is the received character from the UART drive.
REQ-007 i_user_rx_valid  input  1  is a 1-cycle strobe marking i_user_rx_data as valid, with no backpressure.
REQ-008 o_user_tx_data  output  P_DATA_WIDTH  is the character offered to the UART drive transmitter.
REQ-009 o_user_tx_valid  output  1  indicates that o_user_tx_data is valid.
REQ-010 i_user_tx_ready  input  1  indicates the transmitter can accept a character.
REQ-011 o_fifo_count  output  clog2(P_FIFO_DEPTH)+1  is the current FIFO occupancy.
REQ-012 o_overflow  output  1  is a sticky flag set when any character has been dropped.
REQ-013 o_drop_cnt  output  P_CNT_W  counts dropped characters and saturates at its maximum value.

Function
REQ-014 The block SHALL echo every accepted RX character to TX in arrival order through a FIFO of P_FIFO_DEPTH entries.
REQ-015 Write rule: when i_user_rx_valid=1 and the registered count is below P_FIFO_DEPTH, the block SHALL write data at wr_ptr, increment wr_ptr modulo depth, and make the count +1 visible on the next edge.
REQ-016 Full rule: when i_user_rx_valid=1 and the registered count equals P_FIFO_DEPTH, the block SHALL drop the character, even if a read occurs in the same cycle.
REQ-017 On each drop, the block SHALL set o_overflow to 1 and increment o_drop_cnt, saturating at 2^P_CNT_W-1.
REQ-018 Pointers SHALL be clog2(P_FIFO_DEPTH) bits wide and wrap naturally from depth-1 to 0.
REQ-019 Occupancy SHALL be held in a separate counter.
REQ-020 Simultaneous write and read SHALL leave the count unchanged.
REQ-021 The TX state machine SHALL have exactly three states: S_IDLE, S_FETCH and S_SEND.
REQ-022 S_IDLE SHALL go to S_FETCH when the registered count is nonzero; otherwise it SHALL stay in S_IDLE.
REQ-023 S_FETCH SHALL last exactly 1 cycle: it reads mem[rd_ptr] into the output register, increments rd_ptr modulo depth, decrements the count, then goes to S_SEND.
REQ-024 In S_SEND, o_user_tx_valid SHALL be 1 and o_user_tx_data SHALL be held stable.
REQ-025 S_SEND SHALL go to S_IDLE on the cycle where both valid and ready are 1.
REQ-026 o_user_tx_valid SHALL be 1 only in S_SEND, and SHALL never depend combinationally on i_user_tx_ready.
REQ-027 Latency: for an RX strobe at edge N into an empty FIFO in S_IDLE, the count SHALL be 1 after N, S_FETCH SHALL occur in cycle N+1, and o_user_tx_valid SHALL be 1 after edge N+2.
REQ-028 Each character SHALL be transferred exactly once, and o_user_tx_data SHALL change only in S_FETCH.
REQ-029 i_user_tx_ready asserted outside S_SEND SHALL be ignored.
REQ-030 Peak throughput SHALL be one character per 3 cycles, which is far above the UART line rate.
REQ-031 o_fifo_count SHALL be registered and equal to the occupancy counter, so a character in S_FETCH or S_SEND is not counted.

Reset
REQ-032 Asserting i_rst_n=0 at any time, including mid-S_SEND, SHALL immediately clear the following without waiting for a clock edge:
- state to S_IDLE
- pointers and count to 0
- o_user_tx_valid to 0
- o_user_tx_data to 0
- o_overflow to 0
- o_drop_cnt to 0
REQ-033 FIFO memory contents SHALL need no reset, and no output SHALL expose stale memory data after reset.
REQ-034 A character in flight at reset SHALL be discarded, and no TX handshake SHALL occur until a new RX write.
REQ-035 Release of i_rst_n SHALL be synchronised outside this block, and the block SHALL be correct from the first edge after release.

Verification
REQ-036 Single echo: with ready tied to 1, RX 0xA5 at edge N -> valid=1 with data 0xA5 after N+2, valid=0 after N+3, count 1 then 0.
REQ-037 Backpressure: ready=0 for 20 cycles after RX 0x3C -> valid and data stay 1 and 0x3C for all 20 cycles; one transfer after ready=1; no duplicate.
REQ-038 Burst, order and wrap: with ready=0, write 16 bytes 0x00..0x0F, then release ready and write 10 more -> TX sequence 0x00..0x19 in order, with wrap observed on both pointers.
REQ-039 Overflow: with ready=0, write 18 bytes -> count=16, o_overflow=1, o_drop_cnt=2; bytes 17 and 18 are absent from the TX stream.
REQ-040 Drop-counter saturation: with P_CNT_W=2 and a full FIFO, write 5 extra bytes -> o_drop_cnt=3.
REQ-041 Reset mid-operation: assert i_rst_n=0 in S_SEND with 5 bytes queued -> all outputs 0 without a clock edge; after release there is no TX until a new RX byte, which echoes with 2-cycle latency.
